spi_slave_fifo: RTL and testbench

Parametrised next-generation SPI slave for the analyzer command/readback path.
- Supports all four SPI modes (CPOL/CPHA), configurable long-command payload length, and a byte-wide TX FIFO with valid/ready handshake.
- Replaces the fixed-mode, single-word transmit path.
- Sits between the external SPI pins and the core command decoder/readback logic.

---
 rtl/spi_slave_pkg.sv | 18 +
 rtl/full_synchronizer.sv | 26 ++
 rtl/spi_slave_fifo_tx_fifo.sv | 53 +++++
 rtl/spi_slave_fifo.sv | 139 +++++++++++++
 tb/tb_spi_slave_fifo.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and helpers for the SPI slave command/readback path.
package spi_slave_pkg;

   localparam int LONG_CMD_BIT = 7;

   // SPI mode encoded as {CPOL, CPHA}.
   typedef enum logic [1:0] {
      SPI_MODE0 = 2'b00,
      SPI_MODE1 = 2'b01,
      SPI_MODE2 = 2'b10,
      SPI_MODE3 = 2'b11
   } spi_mode_e;

   function automatic int cmd_width(input int opdata_bytes);
      return 8 + 8 * opdata_bytes;
   endfunction

endpackage

// File: rtl/full_synchronizer.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module full_synchronizer #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/spi_slave_fifo_tx_fifo.sv
// Synchronous byte FIFO feeding the SPI transmit shifter; no read bypass.
module spi_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [7:0]               i_din,
   input  logic                     i_pop,
   output logic [7:0]               o_dout,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_dout  = r_mem[r_rd_ptr];
   assign o_level = r_level;

   always_ff @(posedge i_clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave, all four modes: decodes short/long commands from MOSI and streams
// a byte FIFO out on MISO, one FIFO pop per byte slot.
module spi_slave_fifo
   import spi_slave_pkg::*;
#(
   parameter bit CPOL         = 1'b0,
   parameter bit CPHA         = 1'b0,
   parameter int OPDATA_BYTES = 4,
   parameter int TX_DEPTH     = 16
) (
   input  logic                                clock,
   input  logic                                extReset,
   input  logic                                sclk,
   input  logic                                cs,
   input  logic                                mosi,
   output logic                                miso,
   output logic [cmd_width(OPDATA_BYTES)-1:0]  cmd,
   output logic                                execute,
   input  logic [7:0]                          tx_data,
   input  logic                                tx_valid,
   output logic                                tx_ready,
   output logic [$clog2(TX_DEPTH):0]           tx_level,
   output logic                                busy,
   output logic                                underrun
);

   localparam int        CW          = cmd_width(OPDATA_BYTES);
   localparam int        BCW         = $clog2(OPDATA_BYTES + 1);
   localparam spi_mode_e MODE        = spi_mode_e'({CPOL, CPHA});
   localparam logic      SCLK_IDLE   = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
   localparam logic      SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

   logic           w_sclk_s, w_cs_s, w_mosi_s;
   logic           r_sclk_d, r_cs_d;
   logic           w_lead, w_trail, w_active, w_sample, w_shift, w_cs_fall, w_cs_rise;
   logic           w_load;
   logic [2:0]     r_bit_cnt;
   logic [BCW-1:0] r_byte_cnt;
   logic [6:0]     r_rx_sr;
   logic [7:0]     w_rx_byte;
   logic [CW-1:0]  r_part;
   logic [CW-1:0]  w_next_part;
   logic [CW-1:0]  r_cmd;
   logic           r_execute;
   logic           r_underrun;
   logic [7:0]     r_tx_sr;
   logic [7:0]     w_fifo_dout;
   logic           w_fifo_full, w_fifo_empty;

   full_synchronizer #(.RESET_VAL(SCLK_IDLE)) u_sync_sclk (
      .i_clock(clock), .i_reset(extReset), .i_d(sclk), .o_q(w_sclk_s));
   full_synchronizer #(.RESET_VAL(1'b1)) u_sync_cs (
      .i_clock(clock), .i_reset(extReset), .i_d(cs), .o_q(w_cs_s));
   full_synchronizer #(.RESET_VAL(1'b0)) u_sync_mosi (
      .i_clock(clock), .i_reset(extReset), .i_d(mosi), .o_q(w_mosi_s));

   spi_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .i_clock (clock),
      .i_reset (extReset),
      .i_push  (tx_valid),
      .i_din   (tx_data),
      .i_pop   (w_load),
      .o_dout  (w_fifo_dout),
      .o_level (tx_level),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign w_lead    = (w_sclk_s != r_sclk_d) && (w_sclk_s != SCLK_IDLE);
   assign w_trail   = (w_sclk_s != r_sclk_d) && (w_sclk_s == SCLK_IDLE);
   assign w_active  = ~w_cs_s;
   assign w_sample  = w_active && (SAMPLE_LEAD ? w_lead : w_trail);
   assign w_shift   = w_active && (SAMPLE_LEAD ? w_trail : w_lead);
   assign w_cs_fall = r_cs_d & ~w_cs_s;
   assign w_cs_rise = ~r_cs_d & w_cs_s;
   // Leading-sample modes need the first bit on MISO before the first clock edge.
   assign w_load    = (w_shift && (r_bit_cnt == 3'd0)) || (SAMPLE_LEAD && w_cs_fall);
   assign w_rx_byte = {r_rx_sr, w_mosi_s};

   always_comb begin
      w_next_part = r_part;
      for (int k = 0; k <= OPDATA_BYTES; k++) begin
         if (r_byte_cnt == BCW'(k)) w_next_part[8*k +: 8] = w_rx_byte;
      end
   end

   always_ff @(posedge clock) begin
      if (extReset) begin
         r_sclk_d   <= SCLK_IDLE;
         r_cs_d     <= 1'b1;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_rx_sr    <= '0;
         r_part     <= '0;
         r_cmd      <= '0;
         r_execute  <= 1'b0;
         r_underrun <= 1'b0;
         r_tx_sr    <= '0;
      end else begin
         r_sclk_d   <= w_sclk_s;
         r_cs_d     <= w_cs_s;
         r_execute  <= 1'b0;
         r_underrun <= w_load & w_fifo_empty;

         if (w_cs_rise) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_part     <= '0;
         end else if (w_sample) begin
            r_rx_sr   <= w_rx_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               if ((r_byte_cnt == '0) && !w_rx_byte[LONG_CMD_BIT]) begin
                  r_cmd     <= CW'(w_rx_byte);
                  r_execute <= 1'b1;
               end else if (r_byte_cnt == BCW'(OPDATA_BYTES)) begin
                  r_cmd      <= w_next_part;
                  r_execute  <= 1'b1;
                  r_byte_cnt <= '0;
               end else begin
                  r_part     <= w_next_part;
                  r_byte_cnt <= r_byte_cnt + 1'b1;
               end
            end
         end

         if (w_load)       r_tx_sr <= w_fifo_empty ? 8'h00 : w_fifo_dout;
         else if (w_shift) r_tx_sr <= {r_tx_sr[6:0], 1'b0};
      end
   end

   assign miso     = w_active & r_tx_sr[7];
   assign cmd      = r_cmd;
   assign execute  = r_execute;
   assign underrun = r_underrun;
   assign tx_ready = ~w_fifo_full;
   assign busy     = (tx_level != '0) || (w_active && (r_bit_cnt != 3'd0));

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: one instance per SPI mode, driven by a bit-level
// SPI master and checked against a queue-based command/FIFO model.
module tb_spi_slave_fifo;

   localparam int          HALF     = 6;
   localparam logic [63:0] RST_SNAP = 64'h80;

   logic       clock = 1'b0;
   logic       extReset;
   logic [3:0] sclk, cs, mosi, tx_valid, miso, execute, tx_ready, busy, underrun;
   logic [7:0] tx_data  [4];
   logic [39:0] cmd     [4];
   logic [4:0] tx_level [4];

   int n_checks = 0, n_errors = 0;
   int cyc = 0, exec_cyc = 0, last_samp = 0, n_dbl = 0, n_silent = 0;
   int urun [4];
   logic [3:0]  prev_exec = '0;
   logic [39:0] prev_cmd [4];
   logic [39:0] got_q [$];
   logic [7:0]  txq [4][$];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_fifo #(
         .CPOL((g / 2) == 1), .CPHA((g % 2) == 1), .OPDATA_BYTES(4), .TX_DEPTH(16)
      ) u_dut (
         .clock(clock), .extReset(extReset), .sclk(sclk[g]), .cs(cs[g]), .mosi(mosi[g]),
         .miso(miso[g]), .cmd(cmd[g]), .execute(execute[g]), .tx_data(tx_data[g]),
         .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_level(tx_level[g]),
         .busy(busy[g]), .underrun(underrun[g])
      );
   end

   // Scoreboard: collects executed commands, pulse widths and silent cmd changes.
   always @(posedge clock) begin
      #1;
      cyc++;
      for (int k = 0; k < 4; k++) begin
         if (execute[k]) begin
            got_q.push_back(cmd[k]);
            exec_cyc = cyc;
            if (prev_exec[k]) n_dbl++;
         end
         if (underrun[k]) urun[k]++;
         if (!extReset && !execute[k] && (cmd[k] != prev_cmd[k])) n_silent++;
         prev_exec[k] = execute[k];
         prev_cmd[k]  = cmd[k];
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycles=%0d limit reached", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   function automatic logic [63:0] snap(input int k);
      return 64'({cmd[k], execute[k], miso[k], tx_ready[k], busy[k], underrun[k], tx_level[k]});
   endfunction

   task automatic spi_bits(input int m, input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx);
      logic cpol, cpha;
      cpol = (m >= 2);
      cpha = ((m % 2) == 1);
      rx   = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi[m] = tx[7-i];
            wait_cyc(HALF);
            rx = {rx[6:0], miso[m]};
            sclk[m] = ~cpol;
            last_samp = cyc;
            wait_cyc(HALF);
            sclk[m] = cpol;
         end else begin
            sclk[m] = ~cpol;
            mosi[m] = tx[7-i];
            wait_cyc(HALF);
            rx = {rx[6:0], miso[m]};
            sclk[m] = cpol;
            last_samp = cyc;
            wait_cyc(HALF);
         end
      end
   endtask

   task automatic spi_frame(input int m, input logic [7:0] tx[$], output logic [7:0] rx[$]);
      logic [7:0] r;
      rx.delete();
      cs[m] = 1'b0;
      wait_cyc(HALF);
      foreach (tx[i]) begin
         spi_bits(m, tx[i], 8, r);
         rx.push_back(r);
      end
      wait_cyc(HALF);
      cs[m] = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic push_byte(input int m, input logic [7:0] d);
      int t = 0;
      tx_data[m]  = d;
      tx_valid[m] = 1'b1;
      while (!tx_ready[m] && t < 40) begin
         wait_cyc(1);
         t++;
      end
      chk("push_ready", 64'(tx_ready[m]), 64'd1);
      if (tx_ready[m]) txq[m].push_back(d);
      wait_cyc(1);
      tx_valid[m] = 1'b0;
   endtask

   // Command rules: short opcode alone, long opcode plus 4 little-endian bytes;
   // an unfinished long command at frame end is dropped.
   task automatic exp_cmds(input logic [7:0] b[$], output logic [39:0] q[$]);
      int i = 0;
      q.delete();
      while (i < b.size()) begin
         if (!b[i][7]) begin
            q.push_back({32'h0, b[i]});
            i++;
         end else if (i + 4 < b.size()) begin
            q.push_back({b[i+4], b[i+3], b[i+2], b[i+1], b[i]});
            i += 5;
         end else begin
            i = b.size();
         end
      end
   endtask

   // One load per byte slot, plus the load at cs fall in leading-sample modes.
   task automatic model_loads(input int m, input int nbytes, output logic [7:0] exp[$],
                              output int nund);
      int nl;
      nl = nbytes + (((m % 2) == 0) ? 1 : 0);
      exp.delete();
      nund = 0;
      for (int i = 0; i < nl; i++) begin
         if (txq[m].size() > 0) exp.push_back(txq[m].pop_front());
         else begin
            exp.push_back(8'h00);
            nund++;
         end
      end
   endtask

   initial begin
      logic [7:0]  bq [$];
      logic [7:0]  rq [$];
      logic [7:0]  et [$];
      logic [39:0] ec [$];
      logic [7:0]  d, r;
      int u0, nu, acc, m, nb;

      extReset = 1'b1;
      cs       = '1;
      mosi     = '0;
      tx_valid = '0;
      for (int k = 0; k < 4; k++) begin
         sclk[k]    = (k >= 2);
         tx_data[k] = 8'h00;
      end
      wait_cyc(5);
      extReset = 1'b0;
      wait_cyc(3);
      for (int k = 0; k < 4; k++) chk($sformatf("reset_m%0d", k), snap(k), RST_SNAP);

      // Mode 0 short opcode.
      got_q.delete();
      bq.delete(); bq.push_back(8'h02);
      spi_frame(0, bq, rq);
      void'(txq[0].size());
      chk("short_n", 64'(got_q.size()), 64'd1);
      chk("short_cmd", 64'(cmd[0]), 64'h02);
      chk("short_lat", 64'(exec_cyc > last_samp), 64'd1);

      // Mode 3 long opcode.
      got_q.delete();
      bq.delete();
      bq.push_back(8'hC0); bq.push_back(8'h11); bq.push_back(8'h22);
      bq.push_back(8'h33); bq.push_back(8'h44);
      spi_frame(3, bq, rq);
      chk("long_n", 64'(got_q.size()), 64'd1);
      chk("long_cmd", 64'(cmd[3]), 64'h44332211C0);

      // Mode 1 transmit with underrun on the third slot.
      push_byte(1, 8'hA5);
      push_byte(1, 8'h3C);
      wait_cyc(1);
      chk("tx_lvl2", 64'(tx_level[1]), 64'd2);
      u0 = urun[1];
      bq.delete(); bq.push_back(8'h01); bq.push_back(8'h02); bq.push_back(8'h03);
      model_loads(1, 3, et, nu);
      spi_frame(1, bq, rq);
      chk("tx_b0", 64'(rq[0]), 64'hA5);
      chk("tx_b1", 64'(rq[1]), 64'h3C);
      chk("tx_b2", 64'(rq[2]), 64'h00);
      chk("tx_urun", 64'(urun[1] - u0), 64'd1);
      chk("tx_lvl0", 64'(tx_level[1]), 64'd0);

      // Fill to full with valid held high.
      acc = 0;
      tx_valid[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom);
         tx_data[1] = d;
         if (tx_ready[1]) begin
            txq[1].push_back(d);
            acc++;
         end
         wait_cyc(1);
      end
      tx_valid[1] = 1'b0;
      chk("fill_acc", 64'(acc), 64'd16);
      chk("fill_lvl", 64'(tx_level[1]), 64'd16);
      chk("fill_rdy", 64'(tx_ready[1]), 64'd0);
      bq.delete(); bq.push_back(8'h05);
      model_loads(1, 1, et, nu);
      spi_frame(1, bq, rq);
      chk("drain_byte", 64'(rq[0]), 64'(et[0]));
      chk("drain_lvl", 64'(tx_level[1]), 64'd15);
      chk("drain_rdy", 64'(tx_ready[1]), 64'd1);

      // Long command cut short by cs, then a fresh short command.
      got_q.delete();
      bq.delete(); bq.push_back(8'h81); bq.push_back(8'h55); bq.push_back(8'h66);
      spi_frame(0, bq, rq);
      chk("abort_n", 64'(got_q.size()), 64'd0);
      bq.delete(); bq.push_back(8'h04);
      spi_frame(0, bq, rq);
      chk("abort_next_n", 64'(got_q.size()), 64'd1);
      chk("abort_next_cmd", 64'(cmd[0]), 64'h04);

      // Reset in the middle of a mode 2 byte.
      cs[2] = 1'b0;
      wait_cyc(HALF);
      spi_bits(2, 8'hA7, 4, r);
      chk("mid_busy", 64'(busy[2]), 64'd1);
      extReset = 1'b1;
      wait_cyc(1);
      chk("midrst_m2", snap(2), RST_SNAP);
      chk("midrst_m1", snap(1), RST_SNAP);
      cs[2]   = 1'b1;
      sclk[2] = 1'b1;
      wait_cyc(4);
      extReset = 1'b0;
      for (int k = 0; k < 4; k++) txq[k].delete();
      wait_cyc(3);
      got_q.delete();
      bq.delete(); bq.push_back(8'h06);
      spi_frame(2, bq, rq);
      chk("postrst_n", 64'(got_q.size()), 64'd1);
      chk("postrst_cmd", 64'(cmd[2]), 64'h06);

      // Randomised frames against the model.
      for (int it = 0; it < 10; it++) begin
         m = $urandom_range(3, 0);
         for (int p = $urandom_range(4, 0); p > 0; p--) begin
            if (txq[m].size() < 12) push_byte(m, 8'($urandom));
         end
         wait_cyc(1);
         chk($sformatf("rnd%0d_lvl_pre", it), 64'(tx_level[m]), 64'(txq[m].size()));
         nb = $urandom_range(1, 0) ? 5 : $urandom_range(6, 1);
         bq.delete();
         for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
         if (nb == 5 && $urandom_range(1, 0) == 1) bq[0] = bq[0] | 8'h80;
         exp_cmds(bq, ec);
         model_loads(m, nb, et, nu);
         got_q.delete();
         u0 = urun[m];
         spi_frame(m, bq, rq);
         chk($sformatf("rnd%0d_m%0d_ncmd", it, m), 64'(got_q.size()), 64'(ec.size()));
         for (int i = 0; i < ec.size() && i < got_q.size(); i++)
            chk($sformatf("rnd%0d_cmd%0d", it, i), 64'(got_q[i]), 64'(ec[i]));
         for (int i = 0; i < nb; i++)
            chk($sformatf("rnd%0d_miso%0d", it, i), 64'(rq[i]), 64'(et[i]));
         chk($sformatf("rnd%0d_urun", it), 64'(urun[m] - u0), 64'(nu));
         chk($sformatf("rnd%0d_lvl", it), 64'(tx_level[m]), 64'(txq[m].size()));
      end

      chk("exec_width", 64'(n_dbl), 64'd0);
      chk("cmd_silent_change", 64'(n_silent), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
